// File: rtl/demux4_stream_pkg.sv
// demux_pkg: shared types and constants for the demux4_stream slice.
//   lane_sel_t : 2-bit destination lane index carried with each input beat
//   N_LANES    : number of output lanes (4)
//   slot_st_t  : per-lane slot state, EMPTY or FULL
package demux_pkg;

    typedef logic [1:0] lane_sel_t;

    localparam int N_LANES = 4;

    typedef enum logic {EMPTY, FULL} slot_st_t;

endpackage

// File: rtl/demux4_stream_if.sv
// demux4_stream_if: bundles the input stream and the four output streams of
// demux4_stream.
//   in_valid/in_ready/in_data/in_sel : single input stream with lane select
//   out_valid/out_ready/out_data     : four output streams, lane i payload is
//                                      out_data[i*W +: W]
// Modports:
//   slave  : the demux itself (consumes the input stream, produces outputs)
//   master : the environment (produces the input stream, consumes outputs)
interface demux4_stream_if #(
    parameter int W = 4
);
    import demux_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         in_data;
    lane_sel_t            in_sel;
    logic [N_LANES-1:0]   out_valid;
    logic [N_LANES-1:0]   out_ready;
    logic [N_LANES*W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux4_stream_slot.sv
// demux_slot: one-entry register slot for a single output lane.
//   clk, reset : clock and asynchronous active-high reset
//   push       : load din into the slot this cycle
//   pop        : the consumer takes the held beat this cycle
//   din        : payload to load on push
//   valid      : slot holds a beat (state == FULL)
//   dout       : held payload; keeps its last value after the slot drains
module demux_slot
    import demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    slot_st_t state;

    // The upstream in_ready only allows a push when the slot is EMPTY or is
    // being popped in the same cycle, so push always wins: a simultaneous
    // pop and push refills the slot and keeps the lane at full throughput.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            dout  <= '0;
        end else if (push) begin
            state <= FULL;
            dout  <= din;
        end else if (pop) begin
            state <= EMPTY;
        end
    end

    assign valid = (state == FULL);

endmodule

// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 stream demultiplexer. Each accepted input beat is
// steered to the output lane named by in_sel and parked in that lane's
// one-entry slot, so a stalled lane never blocks traffic to the others.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : demux4_stream_if.slave carrying the input and output streams
//   xfer_cnt   : per-lane count of completed output transfers, lane i at
//                xfer_cnt[i*CNT_W +: CNT_W]; present only when the macro
//                DEMUX4_XFER_CNT_EN is defined
module demux4_stream
    import demux_pkg::*;
#(
    parameter int W = 4
`ifdef DEMUX4_XFER_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    demux4_stream_if.slave        bus
`ifdef DEMUX4_XFER_CNT_EN
    ,
    output logic [N_LANES*CNT_W-1:0] xfer_cnt
`endif
);

    logic [N_LANES-1:0] push;
    logic [N_LANES-1:0] pop;
    logic [N_LANES-1:0] valid_q;
    logic [W-1:0]       data_q [N_LANES];
    logic               in_ready;

    // Only the addressed slot gates the input; this is a deliberate
    // combinational path from in_sel and out_ready to in_ready.
    assign in_ready    = !valid_q[bus.in_sel] || bus.out_ready[bus.in_sel];
    assign bus.in_ready = in_ready;

    // One-hot decode of the destination lane for an accepted beat.
    always_comb begin
        push = '0;
        if (bus.in_valid && in_ready) begin
            push[bus.in_sel] = 1'b1;
        end
    end

    assign pop           = valid_q & bus.out_ready;
    assign bus.out_valid = valid_q;

    for (genvar i = 0; i < N_LANES; i++) begin : g_slot
        demux_slot #(.W(W)) u_slot (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (bus.in_data),
            .valid (valid_q[i]),
            .dout  (data_q[i])
        );
    end

    // Flatten the per-lane payloads onto the shared output bus.
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < N_LANES; i++) begin
            bus.out_data[i*W +: W] = data_q[i];
        end
    end

`ifdef DEMUX4_XFER_CNT_EN
    // Free-running per-lane transfer counters; they wrap naturally and are
    // cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                if (pop[i]) begin
                    xfer_cnt[i*CNT_W +: CNT_W] <= xfer_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// tb_demux4_stream: directed self-checking bench for demux4_stream.
// Inputs are driven 1 time unit after a rising edge; registered outputs are
// checked right after that point and combinational in_ready one unit after
// the inputs change. Counter checks run only with DEMUX4_XFER_CNT_EN.
module tb_demux4_stream;
    import demux_pkg::*;

    localparam int W = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    demux4_stream_if #(.W(W)) bus ();

`ifdef DEMUX4_XFER_CNT_EN
    localparam int CNT_W = 8;
    logic [N_LANES*CNT_W-1:0] xfer_cnt;

    demux4_stream #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .xfer_cnt (xfer_cnt)
    );
`else
    demux4_stream #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input lane_sel_t s, input logic [W-1:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input int i);
        return bus.out_data[i*W +: W];
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.out_ready = 4'b0000;
        drive(1'b0, 2'd0, 4'h0);
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'h0);
        check("reset_data", 32'(bus.out_data), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Test 1: fill lanes 1 and 3, then reset mid-run
        drive(1'b1, 2'd1, 4'h9);
        #1;
        check("t1_ready_fill", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd3, 4'h6);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        check("t1_full_valid", 32'(bus.out_valid), 32'b1010);
        check("t1_lane1_data", 32'(lane(1)), 32'h9);
        check("t1_lane3_data", 32'(lane(3)), 32'h6);
        #2;
        reset = 1'b1;
        #1;
        check("t1_async_valid", 32'(bus.out_valid), 32'h0);
        check("t1_async_data", 32'(bus.out_data), 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'd1, 4'h0);
        tick();
        check("t1_ready_after", 32'(bus.in_ready), 32'h1);

        // Test 2: basic routing with all lanes ready
        bus.out_ready = 4'b1111;
        drive(1'b1, 2'd2, 4'hA);
        tick();
        drive(1'b1, 2'd0, 4'h5);
        check("t2_valid_a", 32'(bus.out_valid), 32'b0100);
        check("t2_lane2_a", 32'(lane(2)), 32'hA);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        check("t2_valid_5", 32'(bus.out_valid), 32'b0001);
        check("t2_lane0_5", 32'(lane(0)), 32'h5);
        tick();
        check("t2_drained", 32'(bus.out_valid), 32'b0000);

        // Test 3: lane 1 stalled must not block lane 3
        bus.out_ready = 4'b1101;
        drive(1'b1, 2'd1, 4'h3);
        #1;
        check("t3_ready_first", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd1, 4'h8);
        #1;
        check("t3_ready_blocked", 32'(bus.in_ready), 32'h0);
        tick();
        check("t3_lane1_hold", 32'(lane(1)), 32'h3);
        check("t3_ready_still", 32'(bus.in_ready), 32'h0);
        drive(1'b1, 2'd3, 4'h7);
        #1;
        check("t3_ready_lane3", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        check("t3_valid_both", 32'(bus.out_valid), 32'b1010);
        check("t3_lane3_data", 32'(lane(3)), 32'h7);
        check("t3_lane1_data", 32'(lane(1)), 32'h3);
        tick();
        check("t3_lane3_popped", 32'(bus.out_valid), 32'b0010);
        bus.out_ready = 4'b1111;
        tick();
        check("t3_lane1_popped", 32'(bus.out_valid), 32'b0000);

        // Test 4: back-to-back beats to lane 0
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 2'd0, 4'(k));
            #1;
            check("t4_ready", 32'(bus.in_ready), 32'h1);
            tick();
            check("t4_valid0", 32'(bus.out_valid[0]), 32'h1);
            check("t4_lane0_data", 32'(lane(0)), 32'(k));
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
        check("t4_drained", 32'(bus.out_valid), 32'b0000);

        // Test 5: backpressure hold on lane 2
        bus.out_ready = 4'b1011;
        drive(1'b1, 2'd2, 4'hC);
        tick();
        drive(1'b1, 2'd2, 4'hF);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t5_ready_low", 32'(bus.in_ready), 32'h0);
            tick();
            check("t5_lane2_hold", 32'(lane(2)), 32'hC);
            check("t5_valid2", 32'(bus.out_valid[2]), 32'h1);
        end
        bus.out_ready = 4'b1111;
        #1;
        check("t5_ready_release", 32'(bus.in_ready), 32'h1);
        check("t5_c_first", 32'(lane(2)), 32'hC);
        tick();
        drive(1'b0, 2'd0, 4'h0);
        check("t5_then_f", 32'(lane(2)), 32'hF);
        check("t5_valid_f", 32'(bus.out_valid), 32'b0100);
        tick();
        check("t5_drained", 32'(bus.out_valid), 32'b0000);

`ifdef DEMUX4_XFER_CNT_EN
        // Test 6: 257 pops on lane 3 wrap its counter to 1
        reset = 1'b1;
        #1;
        check("t6_cnt_reset", 32'(xfer_cnt), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 257; k++) begin
            drive(1'b1, 2'd3, 4'(k));
            tick();
        end
        drive(1'b0, 2'd0, 4'h0);
        tick();
        check("t6_cnt_lane3", 32'(xfer_cnt[3*CNT_W +: CNT_W]), 32'd1);
        check("t6_cnt_lane2", 32'(xfer_cnt[2*CNT_W +: CNT_W]), 32'd0);
        check("t6_cnt_lane1", 32'(xfer_cnt[1*CNT_W +: CNT_W]), 32'd0);
        check("t6_cnt_lane0", 32'(xfer_cnt[0 +: CNT_W]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
